// File: rtl/wshb_pkg.sv
// Shared Wishbone constants and grant helpers.
// Pick functions work on an 8-wide vector so any NM up to 8 can share them.
package wshb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR = 2'b00;
   localparam logic [1:0] BTE_WRAP4  = 2'b01;
   localparam logic [1:0] BTE_WRAP8  = 2'b10;
   localparam logic [1:0] BTE_WRAP16 = 2'b11;

   localparam int MAXM = 8;
   localparam int MAXW = 3;

   function automatic logic [MAXM-1:0] rr_pick(
      input logic [MAXM-1:0] req,
      input logic [MAXW-1:0] last,
      input int              nm
   );
      logic [MAXM-1:0] win;
      logic [MAXW-1:0] idx;
      logic            found;
      win   = '0;
      found = 1'b0;
      for (int k = 1; k <= MAXM; k++) begin
         idx = MAXW'((int'(last) + k) % nm);
         if (k <= nm && !found && req[idx]) begin
            win[idx] = 1'b1;
            found    = 1'b1;
         end
      end
      return win;
   endfunction

   function automatic logic [MAXM-1:0] prio_pick(
      input logic [MAXM-1:0] req
   );
      return req & (~req + MAXM'(1));
   endfunction

endpackage

// File: rtl/wshb_arbiter_rr_if.sv
// Bundle of all master-side and slave-side Wishbone signals around the arbiter.
// The arbiter uses the slave modport; the environment uses the master modport.
interface wshb_arbiter_rr_if #(
   parameter int NM = 3,
   parameter int AW = 32,
   parameter int DW = 32
);
   localparam int SW = DW / 8;
   localparam int IW = $clog2(NM);

   logic [NM-1:0] m_cyc;
   logic [NM-1:0] m_stb;
   logic [NM-1:0] m_we;
   logic [AW-1:0] m_adr    [NM];
   logic [DW-1:0] m_dat_ms [NM];
   logic [SW-1:0] m_sel    [NM];
   logic [2:0]    m_cti    [NM];
   logic [1:0]    m_bte    [NM];
   logic [NM-1:0] m_ack;
   logic [NM-1:0] m_err;
   logic [NM-1:0] m_rty;
   logic [DW-1:0] m_dat_sm;

   logic          s_cyc;
   logic          s_stb;
   logic          s_we;
   logic [AW-1:0] s_adr;
   logic [DW-1:0] s_dat_ms;
   logic [SW-1:0] s_sel;
   logic [2:0]    s_cti;
   logic [1:0]    s_bte;
   logic          s_ack;
   logic          s_err;
   logic          s_rty;
   logic [DW-1:0] s_dat_sm;

   logic [NM-1:0] gnt;
   logic [IW-1:0] gnt_idx;

   modport slave (
      input  m_cyc, m_stb, m_we, m_adr, m_dat_ms,
      input  m_sel, m_cti, m_bte,
      output m_ack, m_err, m_rty, m_dat_sm,
      output s_cyc, s_stb, s_we, s_adr, s_dat_ms,
      output s_sel, s_cti, s_bte,
      input  s_ack, s_err, s_rty, s_dat_sm,
      output gnt, gnt_idx
   );

   modport master (
      output m_cyc, m_stb, m_we, m_adr, m_dat_ms,
      output m_sel, m_cti, m_bte,
      input  m_ack, m_err, m_rty, m_dat_sm,
      input  s_cyc, s_stb, s_we, s_adr, s_dat_ms,
      input  s_sel, s_cti, s_bte,
      output s_ack, s_err, s_rty, s_dat_sm,
      input  gnt, gnt_idx
   );

endinterface

// File: rtl/wshb_arbiter_rr_rr_arbiter.sv
// Combinational one-hot picker: round-robin after `last`, or lowest index.
// Output is all zero unless en is high.
module rr_arbiter #(
   parameter int NM   = 3,
   parameter int MODE = 0
) (
   input  logic [NM-1:0]         req,
   input  logic [$clog2(NM)-1:0] last,
   input  logic                  en,
   output logic [NM-1:0]         win
);
   import wshb_pkg::*;

   localparam int IW = $clog2(NM);

   logic [MAXM-1:0] req_w;
   logic [MAXM-1:0] pick;
   logic [MAXW-1:0] last_w;

   always_comb begin
      req_w          = '0;
      req_w[NM-1:0]  = req;
      last_w         = '0;
      last_w[IW-1:0] = last;
      pick = (MODE == 1) ? prio_pick(req_w)
                         : rr_pick(req_w, last_w, NM);
      win  = en ? pick[NM-1:0] : '0;
   end

   // pad lanes above NM are always zero by construction
   if (NM < MAXM) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^pick[MAXM-1:NM];
   end

endmodule

// File: rtl/wshb_arbiter_rr.sv
// N-master Wishbone arbiter: registered one-hot grant held for the whole cyc,
// zero-dead-cycle handover, responses steered only to the owner.
module wshb_arbiter_rr #(
   parameter int NM   = 3,
   parameter int AW   = 32,
   parameter int DW   = 32,
   parameter int MODE = 0
) (
   input  logic              clk,
   input  logic              rst,
   wshb_arbiter_rr_if.slave  bus
);
   import wshb_pkg::*;

   localparam int IW = $clog2(NM);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state, state_n;
   logic [NM-1:0] gnt, gnt_n;
   logic [NM-1:0] req, win;
   logic [IW-1:0] last, last_n;
   logic [IW-1:0] idx, idx_n;
   logic [IW-1:0] win_idx;
   logic          own_cyc;
   logic          en;
   logic          busy;

   rr_arbiter #(
      .NM   (NM),
      .MODE (MODE)
   ) u_arb (
      .req  (req),
      .last (last),
      .en   (en),
      .win  (win)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= '0;
         last  <= IW'(NM - 1);
         idx   <= '0;
      end else begin
         state <= state_n;
         gnt   <= gnt_n;
         last  <= last_n;
         idx   <= idx_n;
      end
   end

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NM; i++)
         if (win[i]) win_idx = IW'(i);
   end

   // owner is masked out so a same-edge re-raise loses to other requesters
   always_comb begin
      own_cyc = bus.m_cyc[idx];
      req     = bus.m_cyc & ~gnt;
      en      = (state == IDLE) || !own_cyc;
      state_n = state;
      gnt_n   = gnt;
      last_n  = last;
      idx_n   = idx;
      unique case (state)
         IDLE: begin
            if (|win) begin
               state_n = BUSY;
               gnt_n   = win;
               idx_n   = win_idx;
               last_n  = win_idx;
            end
         end
         BUSY: begin
            if (!own_cyc) begin
               if (|win) begin
                  gnt_n  = win;
                  idx_n  = win_idx;
                  last_n = win_idx;
               end else begin
                  state_n = IDLE;
                  gnt_n   = '0;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      busy         = (state == BUSY);
      bus.s_cyc    = busy & bus.m_cyc[idx];
      bus.s_stb    = busy & bus.m_stb[idx];
      bus.s_we     = busy & bus.m_we[idx];
      bus.s_adr    = bus.m_adr[idx];
      bus.s_dat_ms = bus.m_dat_ms[idx];
      bus.s_sel    = bus.m_sel[idx];
      bus.s_cti    = bus.m_cti[idx];
      bus.s_bte    = bus.m_bte[idx];
      bus.m_ack    = gnt & {NM{busy & bus.s_ack}};
      bus.m_err    = gnt & {NM{busy & bus.s_err}};
      bus.m_rty    = gnt & {NM{busy & bus.s_rty}};
      bus.m_dat_sm = bus.s_dat_sm;
      bus.gnt      = gnt;
      bus.gnt_idx  = idx;
   end

endmodule

// File: tb/tb_wshb_arbiter_rr.sv
// Scoreboard bench for wshb_arbiter_rr: round-robin instance and
// fixed-priority instance fed by one cycle-based master engine.
module tb_wshb_arbiter_rr;
   import wshb_pkg::*;

   localparam int NM = 3;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wshb_arbiter_rr_if #(.NM(NM), .AW(AW), .DW(DW)) ifa ();
   wshb_arbiter_rr_if #(.NM(NM), .AW(AW), .DW(DW)) ifb ();

   wshb_arbiter_rr #(.NM(NM), .AW(AW), .DW(DW), .MODE(0)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   wshb_arbiter_rr #(.NM(NM), .AW(AW), .DW(DW), .MODE(1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   logic ack_en, err_en, ack_force, dsel;

   always_comb begin
      ifa.s_ack    = ack_force | (ack_en & ifa.s_cyc & ifa.s_stb);
      ifa.s_err    = err_en & ifa.s_cyc & ifa.s_stb;
      ifa.s_rty    = 1'b0;
      ifa.s_dat_sm = ifa.s_adr ^ 32'hA5A5_0000;
      ifb.s_ack    = ack_force | (ack_en & ifb.s_cyc & ifb.s_stb);
      ifb.s_err    = err_en & ifb.s_cyc & ifb.s_stb;
      ifb.s_rty    = 1'b0;
      ifb.s_dat_sm = ifb.s_adr ^ 32'hA5A5_0000;
   end

   logic [NM-1:0] a_ack, a_err, a_rty, a_gnt;
   logic [1:0]    a_idx;
   logic [31:0]   a_adr, a_dat, a_dms;
   logic [3:0]    a_sel;
   logic [2:0]    a_cti;
   logic          a_cyc, a_we;

   always_comb begin
      if (dsel) begin
         a_ack = ifb.m_ack;  a_err = ifb.m_err;  a_rty = ifb.m_rty;
         a_gnt = ifb.gnt;    a_idx = ifb.gnt_idx; a_adr = ifb.s_adr;
         a_dat = ifb.m_dat_sm; a_dms = ifb.s_dat_ms; a_sel = ifb.s_sel;
         a_cti = ifb.s_cti;  a_cyc = ifb.s_cyc;  a_we  = ifb.s_we;
      end else begin
         a_ack = ifa.m_ack;  a_err = ifa.m_err;  a_rty = ifa.m_rty;
         a_gnt = ifa.gnt;    a_idx = ifa.gnt_idx; a_adr = ifa.s_adr;
         a_dat = ifa.m_dat_sm; a_dms = ifa.s_dat_ms; a_sel = ifa.s_sel;
         a_cti = ifa.s_cti;  a_cyc = ifa.s_cyc;  a_we  = ifa.s_we;
      end
   end

   int cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   typedef struct {
      int          m;
      bit          err;
      logic [31:0] adr;
      logic [2:0]  cti;
      int          cyc;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   fails  = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: every forwarded response must match the oldest expectation
   always @(negedge clk) begin
      if ((|a_ack) || (|a_err)) begin
         if (q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_resp: got ack %b err %b expected none",
                     a_ack, a_err);
         end else begin
            logic [NM-1:0] oh;
            e     = q.pop_front();
            oh    = '0;
            oh[e.m] = 1'b1;
            chk("resp_gnt", 32'(a_gnt), 32'(oh));
            chk("resp_ack", 32'(a_ack), e.err ? 32'd0 : 32'(oh));
            chk("resp_err", 32'(a_err), e.err ? 32'(oh) : 32'd0);
            chk("resp_rty", 32'(a_rty), 32'd0);
            chk("resp_adr", a_adr, e.adr);
            chk("resp_dat", a_dat, e.adr ^ 32'hA5A5_0000);
            chk("resp_dms", a_dms, e.adr ^ 32'h0F0F_0000);
            chk("resp_sel", 32'(a_sel), 32'(4'hF >> e.m));
            chk("resp_we",  32'(a_we), 32'(e.m % 2));
            chk("resp_cti", 32'(a_cti), 32'(e.cti));
            chk("resp_cycle", 32'(cyc_n), 32'(e.cyc));
         end
      end
   end

   int          left  [NM];
   int          jobs  [NM];
   int          start [NM];
   int          nb    [NM];
   int          bidx  [NM];
   bit          hold  [NM];
   logic [31:0] base  [NM];
   int          rst_at  = -1;
   int          abort_m = 0;
   int          base_c  = 0;

   task automatic clear_jobs();
      for (int m = 0; m < NM; m++) begin
         left[m] = 0;  jobs[m] = 0;  start[m] = 0;  nb[m] = 1;
         bidx[m] = 0;  hold[m] = 1'b0;  base[m] = 32'(m * 16);
      end
   endtask

   task automatic job(input int m, input int st, input int n,
                      input int rp, input logic [31:0] b);
      start[m] = st;  nb[m] = n;  jobs[m] = rp;  base[m] = b;
   endtask

   task automatic push(input int m, input bit err, input logic [31:0] adr,
                       input logic [2:0] cti, input int dc);
      exp_t x;
      x.m = m;  x.err = err;  x.adr = adr;  x.cti = cti;  x.cyc = base_c + dc;
      q.push_back(x);
   endtask

   function automatic bit idle_all();
      bit r;
      r = 1'b1;
      for (int m = 0; m < NM; m++)
         if (left[m] != 0 || jobs[m] != 0) r = 1'b0;
      return r;
   endfunction

   task automatic drive(input int t);
      logic        c;
      logic [31:0] adr;
      logic [2:0]  cti;
      if (rst_at >= 0) begin
         rst = (t == rst_at);
         if (t == rst_at + 1) begin
            left[abort_m] = 0;
            jobs[abort_m] = 0;
         end
      end
      for (int m = 0; m < NM; m++) begin
         if (hold[m]) hold[m] = 1'b0;
         else if (left[m] == 0 && jobs[m] > 0 && t >= start[m]) begin
            left[m] = nb[m];
            jobs[m]--;
         end
         c   = (left[m] > 0);
         adr = base[m] + 32'(4 * bidx[m]);
         if (nb[m] == 1)       cti = CTI_CLASSIC;
         else if (left[m] == 1) cti = CTI_EOB;
         else                  cti = CTI_INCR;
         ifa.m_cyc[m] = c;  ifb.m_cyc[m] = c;
         ifa.m_stb[m] = c;  ifb.m_stb[m] = c;
         ifa.m_we[m]  = 1'(m % 2);  ifb.m_we[m] = 1'(m % 2);
         ifa.m_adr[m] = adr;  ifb.m_adr[m] = adr;
         ifa.m_dat_ms[m] = adr ^ 32'h0F0F_0000;
         ifb.m_dat_ms[m] = adr ^ 32'h0F0F_0000;
         ifa.m_sel[m] = 4'(4'hF >> m);  ifb.m_sel[m] = 4'(4'hF >> m);
         ifa.m_cti[m] = cti;  ifb.m_cti[m] = cti;
         ifa.m_bte[m] = BTE_LINEAR;  ifb.m_bte[m] = BTE_LINEAR;
      end
   endtask

   task automatic sample(input int t);
      for (int m = 0; m < NM; m++) begin
         if ((a_ack[m] || a_err[m]) && left[m] > 0) begin
            left[m]--;
            bidx[m]++;
            if (left[m] == 0) hold[m] = 1'b1;
         end
      end
      if (rst_at >= 0 && t == rst_at + 1) begin
         chk("rst_scyc", 32'(a_cyc), 32'd0);
         chk("rst_gnt", 32'(a_gnt), 32'd0);
      end
   endtask

   task automatic run(input int budget);
      int t;
      bit done;
      done = 1'b0;
      for (t = 0; t < budget && !done; t++) begin
         drive(t);
         @(negedge clk);
         sample(t);
         done = idle_all();
         @(posedge clk);
         #1;
      end
      chk("run_done", 32'(done), 32'd1);
      rst_at = -1;
      drive(t);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("sb_empty", 32'(q.size()), 32'd0);
   endtask

   task automatic do_reset();
      clear_jobs();
      rst_at = -1;
      drive(0);
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_gnt", 32'(a_gnt), 32'd0);
      chk("reset_idx", 32'(a_idx), 32'd0);
      chk("reset_scyc", 32'(a_cyc), 32'd0);
      chk("reset_ack", 32'(a_ack | a_err | a_rty), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      ack_en = 1'b1;  err_en = 1'b0;  ack_force = 1'b0;  dsel = 1'b0;
      clear_jobs();
      drive(0);
      @(posedge clk);
      #1;

      // single request from master 1
      do_reset();
      job(1, 0, 1, 1, 32'h100);
      base_c = cyc_n;
      push(1, 1'b0, 32'h100, CTI_CLASSIC, 1);
      run(20);

      // three simultaneous requesters take turns 0, 1, 2
      do_reset();
      job(0, 0, 1, 1, 32'h200);
      job(1, 0, 1, 1, 32'h300);
      job(2, 0, 1, 1, 32'h400);
      base_c = cyc_n;
      push(0, 1'b0, 32'h200, CTI_CLASSIC, 1);
      push(1, 1'b0, 32'h300, CTI_CLASSIC, 3);
      push(2, 1'b0, 32'h400, CTI_CLASSIC, 5);
      run(20);

      // 8-beat burst from master 0 is not split by master 2
      do_reset();
      job(0, 0, 8, 1, 32'h1000);
      job(2, 2, 1, 1, 32'h2000);
      base_c = cyc_n;
      for (int k = 0; k < 8; k++)
         push(0, 1'b0, 32'h1000 + 32'(4 * k),
              (k == 7) ? CTI_EOB : CTI_INCR, k + 1);
      push(2, 1'b0, 32'h2000, CTI_CLASSIC, 10);
      run(30);

      // reset during master 2's burst, then master 0 requests
      do_reset();
      job(2, 0, 8, 1, 32'h3000);
      job(0, 4, 1, 1, 32'h4000);
      rst_at  = 3;
      abort_m = 2;
      base_c  = cyc_n;
      push(2, 1'b0, 32'h3000, CTI_INCR, 1);
      push(2, 1'b0, 32'h3004, CTI_INCR, 2);
      push(2, 1'b0, 32'h3008, CTI_INCR, 3);
      push(0, 1'b0, 32'h4000, CTI_CLASSIC, 5);
      run(30);

      // slave ack while idle is dropped; read data still broadcast
      do_reset();
      ifa.m_adr[0] = 32'h5000;
      ifb.m_adr[0] = 32'h5000;
      ack_force = 1'b1;
      @(negedge clk);
      chk("idle_ack", 32'(a_ack | a_err), 32'd0);
      chk("idle_dat", a_dat, 32'h5000 ^ 32'hA5A5_0000);
      chk("idle_adr", a_adr, 32'h5000);
      chk("idle_scyc", 32'(a_cyc), 32'd0);
      @(posedge clk);
      #1;
      ack_force = 1'b0;

      // error response goes only to master 1
      ack_en = 1'b0;
      err_en = 1'b1;
      job(1, 0, 1, 1, 32'h600);
      base_c = cyc_n;
      push(1, 1'b1, 32'h600, CTI_CLASSIC, 1);
      run(20);
      ack_en = 1'b1;
      err_en = 1'b0;

      // fixed priority: master 1 beats master 2 whenever both request
      dsel = 1'b1;
      do_reset();
      job(1, 0, 1, 1, 32'h700);
      base_c = cyc_n;
      push(1, 1'b0, 32'h700, CTI_CLASSIC, 1);
      run(20);
      clear_jobs();
      job(1, 0, 1, 2, 32'h800);
      job(2, 0, 1, 2, 32'h900);
      base_c = cyc_n;
      push(1, 1'b0, 32'h800, CTI_CLASSIC, 1);
      push(2, 1'b0, 32'h900, CTI_CLASSIC, 3);
      push(1, 1'b0, 32'h804, CTI_CLASSIC, 5);
      push(2, 1'b0, 32'h904, CTI_CLASSIC, 7);
      run(30);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
